alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cmd_valid  in  1  command offered.
REQ-004 SHALL have: cmd_ready  out  1  stage can accept a command.
REQ-005 SHALL have: cmd_op  in  2  00 ALU op, 01 MOVI (load immediate), 1x reserved (treated as no-op).
REQ-006 SHALL have: cmd_aluop  in  2  00 add, 01 sub, 10 and, 11 not-B.
REQ-007 SHALL have: cmd_rn, cmd_rm, cmd_rd  in  3 each  source A, source B, destination register.
REQ-008 SHALL have: cmd_shift  in  2  B-operand shift: 00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1.
REQ-009 SHALL have: cmd_imm  in  16  MOVI value.
REQ-010 SHALL have: alu_a, alu_b  out  16  operands to external ALU; alu_op  out  2  opcode to ALU.
REQ-011 SHALL have: alu_out  in  16  and alu_z  in  1  combinational ALU result and zero flag.
REQ-012 SHALL have: c_out  out  16  result register; z_flag  out  1  status register; done  out  1  completion pulse.
REQ-013 SHALL have: dbg_sel  in  3  and dbg_data  out  16  combinational read of any register.

Function
REQ-014 SHALL hold eight 16-bit registers R0..R7; one write port, two synchronous-capture read paths.
REQ-015 SHALL implement states IDLE, FETCH, EXEC, WB; cmd_ready SHALL be 1 only in IDLE.
REQ-016 Handshake: command accepted on a rising edge with cmd_valid=1 and cmd_ready=1; all cmd_* fields latched on that edge.
REQ-017 ALU op: IDLE->FETCH->EXEC->WB->IDLE; FETCH latches A=R[rn], B=shift(R[rm]).
REQ-018 EXEC SHALL drive alu_a=A, alu_b=B, alu_op=latched aluop; at end of EXEC capture alu_out into C and alu_z into Z.
REQ-019 WB SHALL write C into R[rd] and assert done for exactly one cycle; latency accept-edge to done-high = 3 cycles.
REQ-020 MOVI: IDLE->WB; WB writes cmd_imm into R[rd], done pulses; C and Z unchanged; latency 1 cycle.
REQ-021 Reserved cmd_op: accepted, returns to IDLE next cycle, no register/C/Z change, no done.
REQ-022 alu_a/alu_b/alu_op SHALL be driven from the A, B, op registers in all states (stable outside EXEC).
REQ-023 rd equal to rn or rm: reads use pre-write values; write lands in WB.
REQ-024 Shift is 16-bit: left drops bit15, shifts in 0; logical right shifts in 0; arithmetic right replicates bit15.
REQ-025 Arithmetic wrap-around is the ALU's; stage SHALL pass 16-bit results unmodified.
REQ-026 cmd_valid while busy SHALL be ignored; upstream holds the command until cmd_ready.
REQ-027 dbg_data SHALL reflect R[dbg_sel], including a WB write from the following cycle onward.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, R0..R7=0, A=B=0, op=00, C=0, Z=0, done=0, cmd_ready=1 once released.
REQ-029 Reset mid-operation SHALL abort with no register write and no done pulse.

Structure
REQ-030 Package alu_issue_pkg SHALL hold state enum, cmd_op enum, shift enum, ALU opcode constants, width constants (16 data, 3 index).
REQ-031 One sub-module, regfile (8x16, one write, two read), SHALL be instantiated; the ALU stays external.

Verification
REQ-032 Reset then dbg_sel sweep 0..7 -> dbg_data=0 each; c_out=0, z_flag=0, cmd_ready=1.
REQ-033 MOVI R1=7, MOVI R2=2, ADD rd=R3 rn=R1 rm=R2 -> done 3 cycles after ADD accept; R3=9, c_out=9, z_flag=0.
REQ-034 SUB rd=R4 rn=R1 rm=R1 (R1=7) -> R4=0, z_flag=1; then NOT-B rm=R4 -> 0xFFFF, z_flag=0.
REQ-035 R5=0x8002; shifts 01/10/11 via ADD with R0=0 -> 0x0004, 0x4001, 0xC001.
REQ-036 cmd_valid held high across a busy ALU op -> second command accepted only when cmd_ready returns, exactly one done per command.
REQ-037 rst_n low during EXEC of ADD into R6 -> R6 stays 0, no done, c_out=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage: FSM states, command
// encodings, operand shift modes and the external ALU opcodes.
package alu_issue_pkg;

   localparam int DATA_W   = 16;
   localparam int IDX_W    = 3;
   localparam int NUM_REGS = 1 << IDX_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_EXEC  = 2'b10,
      S_WB    = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      OP_ALU   = 2'b00,
      OP_MOVI  = 2'b01,
      OP_RSVD2 = 2'b10,
      OP_RSVD3 = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   // One-bit shift of the B operand; arithmetic right keeps the sign bit.
   function automatic logic [DATA_W-1:0] shift_operand(input logic [DATA_W-1:0] v,
                                                       input shift_e sh);
      case (sh)
         SH_LSL1: return {v[DATA_W-2:0], 1'b0};
         SH_LSR1: return {1'b0, v[DATA_W-1:1]};
         SH_ASR1: return {v[DATA_W-1], v[DATA_W-1:1]};
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Eight-entry register file: one synchronous write port, two operand read
// ports and one debug read port, all reads combinational.
module alu_issue_stage_regfile
   import alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [IDX_W-1:0]  raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o,
   input  logic [IDX_W-1:0]  raddr_dbg_i,
   output logic [DATA_W-1:0] rdata_dbg_o
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   // NOTE: this storage is flops, not a RAM macro, so clearing every entry on reset is legal and required here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o   = mem_q[raddr_a_i];
   assign rdata_b_o   = mem_q[raddr_b_i];
   assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for an external combinational ALU: accepts one command at a time,
// fetches and shifts operands, captures the ALU result and writes it back.
module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [1:0]        cmd_aluop,
   input  logic [IDX_W-1:0]  cmd_rn,
   input  logic [IDX_W-1:0]  cmd_rm,
   input  logic [IDX_W-1:0]  cmd_rd,
   input  logic [1:0]        cmd_shift,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_z,
   output logic [DATA_W-1:0] c_out,
   output logic              z_flag,
   output logic              done,
   input  logic [IDX_W-1:0]  dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            state_q;
   cmd_op_e           op_q;
   logic [1:0]        aluop_q;
   logic [IDX_W-1:0]  rn_q, rm_q, rd_q;
   shift_e            shift_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] a_q, b_q, c_q;
   logic [1:0]        alu_op_q;
   logic              z_q;
   logic              done_q;

   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rdata_a, rdata_b;

   // MOVI writes its immediate; ALU ops write the captured result.
   assign rf_we    = (state_q == S_WB);
   assign rf_wdata = (op_q == OP_MOVI) ? imm_q : c_q;

   alu_issue_stage_regfile u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .we_i        (rf_we),
      .waddr_i     (rd_q),
      .wdata_i     (rf_wdata),
      .raddr_a_i   (rn_q),
      .rdata_a_o   (rdata_a),
      .raddr_b_i   (rm_q),
      .rdata_b_o   (rdata_b),
      .raddr_dbg_i (dbg_sel),
      .rdata_dbg_o (dbg_data)
   );

   // NOTE: non-blocking assignments make every register sample pre-edge values, so FETCH sees R[rn]/R[rm] before any write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ALU;
         aluop_q  <= ALU_ADD;
         rn_q     <= '0;
         rm_q     <= '0;
         rd_q     <= '0;
         shift_q  <= SH_NONE;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         alu_op_q <= ALU_ADD;
         c_q      <= '0;
         z_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op_e'(cmd_op);
                  aluop_q <= cmd_aluop;
                  rn_q    <= cmd_rn;
                  rm_q    <= cmd_rm;
                  rd_q    <= cmd_rd;
                  shift_q <= shift_e'(cmd_shift);
                  imm_q   <= cmd_imm;
                  case (cmd_op_e'(cmd_op))
                     OP_ALU:  state_q <= S_FETCH;
                     OP_MOVI: begin
                        state_q <= S_WB;
                        done_q  <= 1'b1;
                     end
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
            S_FETCH: begin
               a_q      <= rdata_a;
               b_q      <= shift_operand(rdata_b, shift_q);
               alu_op_q <= aluop_q;
               state_q  <= S_EXEC;
            end
            S_EXEC: begin
               c_q     <= alu_out;
               z_q     <= alu_z;
               done_q  <= 1'b1;
               state_q <= S_WB;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = alu_op_q;
   assign c_out     = c_q;
   assign z_flag    = z_q;
   assign done      = done_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural external ALU, a table
// of commands with hand-derived results, and directed busy/reset sequences.
module tb_alu_issue_stage;
   import alu_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op, cmd_aluop, cmd_shift;
   logic [2:0]  cmd_rn, cmd_rm, cmd_rd;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_op;
   logic        alu_z;
   logic [15:0] c_out;
   logic        z_flag, done;
   logic [2:0]  dbg_sel;
   logic [15:0] dbg_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [1:0]  aluop;
      logic [2:0]  rn;
      logic [2:0]  rm;
      logic [2:0]  rd;
      logic [1:0]  sh;
      logic [15:0] imm;
      logic [15:0] exp_reg;
      logic [15:0] exp_c;
      logic        exp_z;
      int          exp_lat;   // 0 means no done pulse expected
   } vec_t;

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] reg_val;
      logic [15:0] c;
      logic        z;
      int          lat;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[13];

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // External combinational ALU.
   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_ADD:  alu_out = alu_a + alu_b;
         ALU_SUB:  alu_out = alu_a - alu_b;
         ALU_AND:  alu_out = alu_a & alu_b;
         default:  alu_out = ~alu_b;
      endcase
   end
   assign alu_z = (alu_out == 16'h0000);

   alu_issue_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_aluop (cmd_aluop),
      .cmd_rn    (cmd_rn),
      .cmd_rm    (cmd_rm),
      .cmd_rd    (cmd_rd),
      .cmd_shift (cmd_shift),
      .cmd_imm   (cmd_imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_z     (alu_z),
      .c_out     (c_out),
      .z_flag    (z_flag),
      .done      (done),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic [1:0] aluop, input logic [2:0] rn,
                            input logic [2:0] rm, input logic [2:0] rd, input logic [1:0] sh,
                            input logic [15:0] imm);
      cmd_op    = op;
      cmd_aluop = aluop;
      cmd_rn    = rn;
      cmd_rm    = rm;
      cmd_rd    = rd;
      cmd_shift = sh;
      cmd_imm   = imm;
   endtask

   task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
      dbg_sel = idx;
      #1;
      val = dbg_data;
   endtask

   task automatic run_vec(input vec_t v);
      int          wait_cnt;
      int          lat;
      sb_t         e;
      logic [15:0] rv;
      @(negedge clk);
      drive_cmd(v.op, v.aluop, v.rn, v.rm, v.rd, v.sh, v.imm);
      cmd_valid = 1'b1;
      wait_cnt = 0;
      while (!cmd_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      check({v.name, "_ready"}, cmd_ready, 1);
      @(posedge clk);
      sb_q.push_back('{rd: v.rd, reg_val: v.exp_reg, c: v.exp_c, z: v.exp_z, lat: v.exp_lat});
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      if (sb_q.size() == 0) begin
         check({v.name, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb_q.pop_front();
      if (e.lat == 0) begin
         check({v.name, "_no_done"}, done, 0);
      end else begin
         check({v.name, "_latency"}, lat, e.lat);
         @(negedge clk);
         check({v.name, "_done_width"}, done, 0);
      end
      check({v.name, "_c_out"}, c_out, e.c);
      check({v.name, "_z_flag"}, z_flag, e.z);
      read_reg(e.rd, rv);
      check({v.name, "_reg"}, rv, e.reg_val);
   endtask

   initial begin
      logic [15:0] rv;
      logic [15:0] final_regs [8];
      int          accepts, dones, acc_k[2];
      bit          pending;

      vecs[0]  = '{"movi_r1",     2'b01, ALU_ADD,  3'd0, 3'd0, 3'd1, 2'b00, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1};
      vecs[1]  = '{"movi_r2",     2'b01, ALU_ADD,  3'd0, 3'd0, 3'd2, 2'b00, 16'h0002, 16'h0002, 16'h0000, 1'b0, 1};
      vecs[2]  = '{"add_r3",      2'b00, ALU_ADD,  3'd1, 3'd2, 3'd3, 2'b00, 16'h0000, 16'h0009, 16'h0009, 1'b0, 3};
      vecs[3]  = '{"sub_r4",      2'b00, ALU_SUB,  3'd1, 3'd1, 3'd4, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3};
      vecs[4]  = '{"notb_r7",     2'b00, ALU_NOTB, 3'd0, 3'd4, 3'd7, 2'b00, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 3};
      vecs[5]  = '{"movi_r5",     2'b01, ALU_ADD,  3'd0, 3'd0, 3'd5, 2'b00, 16'h8002, 16'h8002, 16'hFFFF, 1'b0, 1};
      vecs[6]  = '{"shift_lsl",   2'b00, ALU_ADD,  3'd0, 3'd5, 3'd3, 2'b01, 16'h0000, 16'h0004, 16'h0004, 1'b0, 3};
      vecs[7]  = '{"shift_lsr",   2'b00, ALU_ADD,  3'd0, 3'd5, 3'd3, 2'b10, 16'h0000, 16'h4001, 16'h4001, 1'b0, 3};
      vecs[8]  = '{"shift_asr",   2'b00, ALU_ADD,  3'd0, 3'd5, 3'd3, 2'b11, 16'h0000, 16'hC001, 16'hC001, 1'b0, 3};
      vecs[9]  = '{"reserved_op", 2'b10, ALU_ADD,  3'd0, 3'd0, 3'd1, 2'b00, 16'hBEEF, 16'h0007, 16'hC001, 1'b0, 0};
      vecs[10] = '{"and_r2",      2'b00, ALU_AND,  3'd5, 3'd7, 3'd2, 2'b00, 16'h0000, 16'h8002, 16'h8002, 1'b0, 3};
      vecs[11] = '{"rd_eq_rn_rm", 2'b00, ALU_ADD,  3'd1, 3'd1, 3'd1, 2'b00, 16'h0000, 16'h000E, 16'h000E, 1'b0, 3};
      vecs[12] = '{"add_wrap",    2'b00, ALU_ADD,  3'd7, 3'd1, 3'd4, 2'b00, 16'h0000, 16'h000D, 16'h000D, 1'b0, 3};

      final_regs = '{16'h0000, 16'h000E, 16'h8002, 16'hC001, 16'h000D, 16'h8002, 16'h0000, 16'hFFFF};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      dbg_sel   = '0;
      drive_cmd(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), rv);
         check($sformatf("reset_r%0d", i), rv, 16'h0000);
      end
      check("reset_c_out", c_out, 16'h0000);
      check("reset_z_flag", z_flag, 0);
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_done", done, 0);
      check("reset_alu_a", alu_a, 16'h0000);

      foreach (vecs[i]) run_vec(vecs[i]);

      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), rv);
         check($sformatf("final_r%0d", i), rv, final_regs[i]);
      end

      // Second command held valid while the first is busy: R2 = R1+R1 = 0x1C, then MOVI R2=0x1234.
      @(negedge clk);
      drive_cmd(2'b00, ALU_ADD, 3'd1, 3'd1, 3'd2, 2'b00, 16'h0000);
      cmd_valid = 1'b1;
      pending   = cmd_ready;
      accepts   = 0;
      dones     = 0;
      acc_k     = '{0, 0};
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done) dones++;
         if (pending) begin
            if (accepts < 2) acc_k[accepts] = k;
            accepts++;
            if (accepts == 1) drive_cmd(2'b01, ALU_ADD, 3'd0, 3'd0, 3'd2, 2'b00, 16'h1234);
            else              cmd_valid = 1'b0;
         end
         pending = cmd_valid && cmd_ready;
      end
      check("busy_accepts", accepts, 2);
      check("busy_dones", dones, 2);
      check("busy_accept_gap", acc_k[1] - acc_k[0], 4);
      check("busy_c_out", c_out, 16'h001C);
      read_reg(3'd2, rv);
      check("busy_r2", rv, 16'h1234);

      // Reset asserted while an ADD into R6 is in EXEC.
      @(negedge clk);
      drive_cmd(2'b00, ALU_ADD, 3'd1, 3'd1, 3'd6, 2'b00, 16'h0000);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_in_exec", cmd_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_c_out", c_out, 16'h0000);
      check("abort_done", done, 0);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_alu_a", alu_a, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_c_out_after", c_out, 16'h0000);
      read_reg(3'd6, rv);
      check("abort_r6", rv, 16'h0000);
      read_reg(3'd1, rv);
      check("abort_r1_cleared", rv, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
